checksum_seq: RTL and testbench

CHECKSUM_SEQ -- requirements
Module: checksum_seq

---
 rtl/checksum_pkg.sv | 13 +
 rtl/ocadd16.sv | 18 +
 rtl/checksum_seq.sv | 87 ++++++++
 tb/tb_checksum_seq.sv | 231 +++++++++++++++++++++++
 4 files changed

// File: rtl/checksum_pkg.sv
// Shared definitions for the one's-complement checksum sequencer.
package checksum_pkg;

    localparam int SUM_W     = 16;
    localparam int LEN_W_DEF = 4;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ACCUM = 2'd1,
        DONE  = 2'd2
    } state_t;

endpackage

// File: rtl/ocadd16.sv
// 16-bit one's-complement adder: the carry-out is folded back into bit 0.
module ocadd16
    import checksum_pkg::*;
(
    input  logic [SUM_W-1:0] a,
    input  logic [SUM_W-1:0] b,
    output logic [SUM_W-1:0] sum
);

    logic [SUM_W:0] raw;

    // The largest raw sum is 0x1FFFE, so re-adding the carry never carries again.
    always_comb begin
        raw = {1'b0, a} + {1'b0, b};
        sum = raw[SUM_W-1:0] + {{(SUM_W-1){1'b0}}, raw[SUM_W]};
    end

endmodule

// File: rtl/checksum_seq.sv
// Sequential Internet-style checksum over a block of 32-bit words; each word
// contributes two 16-bit addends, and the result is the complemented sum.
module checksum_seq
    import checksum_pkg::*;
#(
    parameter int LEN_W = LEN_W_DEF
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [LEN_W-1:0] len,
    output logic             busy,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [31:0]      in_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [SUM_W-1:0] out_csum
);

    state_t             state, state_nxt;
    logic [SUM_W-1:0]   acc, acc_nxt;
    logic [LEN_W-1:0]   cnt, cnt_nxt;
    logic [SUM_W-1:0]   sum_hi, sum_lo;
    logic               accept;

    ocadd16 u_add_hi (
        .a   (acc),
        .b   (in_data[31:16]),
        .sum (sum_hi)
    );

    ocadd16 u_add_lo (
        .a   (sum_hi),
        .b   (in_data[15:0]),
        .sum (sum_lo)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= IDLE;
            acc   <= '0;
            cnt   <= '0;
        end else begin
            state <= state_nxt;
            acc   <= acc_nxt;
            cnt   <= cnt_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        acc_nxt   = acc;
        cnt_nxt   = cnt;
        busy      = (state != IDLE);
        in_ready  = (state == ACCUM);
        out_valid = (state == DONE);
        out_csum  = (state == DONE) ? ~acc : '0;
        accept    = in_valid && (state == ACCUM);

        unique case (state)
            IDLE: begin
                if (start) begin
                    acc_nxt   = '0;
                    cnt_nxt   = len;
                    state_nxt = (len == '0) ? DONE : ACCUM;
                end
            end
            ACCUM: begin
                if (accept) begin
                    acc_nxt = sum_lo;
                    cnt_nxt = cnt - 1'b1;
                    if (cnt == {{(LEN_W-1){1'b0}}, 1'b1}) begin
                        state_nxt = DONE;
                    end
                end
            end
            DONE: begin
                if (out_ready) begin
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

endmodule

// File: tb/tb_checksum_seq.sv
// Directed bench for checksum_seq with a transaction-level reference model.
module tb_checksum_seq;

    logic        clk;
    logic        rst_n;
    logic        start;
    logic [3:0]  len;
    logic        busy;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] in_data;
    logic        out_valid;
    logic        out_ready;
    logic [15:0] out_csum;

    int total = 0;
    int bad   = 0;

    checksum_seq #(.LEN_W(4)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (start),
        .len       (len),
        .busy      (busy),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_csum  (out_csum)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: job phase (0 idle, 1 collecting words, 2 result held),
    // a wide plain-integer running sum folded only when the result is needed.
    int              m_phase = 0;
    int              m_rem   = 0;
    longint unsigned m_sum   = 0;
    bit              m_init  = 1'b0;

    function automatic logic [15:0] fold_csum(input longint unsigned s);
        longint unsigned t = s;
        while ((t >> 16) != 0) t = (t & 64'hFFFF) + (t >> 16);
        return ~t[15:0];
    endfunction

    always @(posedge clk) begin
        if (!rst_n) begin
            m_phase = 0;
            m_rem   = 0;
            m_sum   = 0;
            m_init  = 1'b1;
        end else if (m_phase == 0) begin
            if (start) begin
                m_sum   = 0;
                m_rem   = int'(len);
                m_phase = (len == 0) ? 2 : 1;
            end
        end else if (m_phase == 1) begin
            if (in_valid) begin
                m_sum = m_sum + in_data[31:16] + in_data[15:0];
                m_rem--;
                if (m_rem == 0) m_phase = 2;
            end
        end else begin
            if (out_ready) m_phase = 0;
        end
    end

    always @(negedge clk) begin
        if (m_init) begin
            chk("busy",      32'(busy),      32'(m_phase != 0));
            chk("in_ready",  32'(in_ready),  32'(m_phase == 1));
            chk("out_valid", 32'(out_valid), 32'(m_phase == 2));
            chk("out_csum",  32'(out_csum),  (m_phase == 2) ? 32'(fold_csum(m_sum)) : 32'h0);
        end
    end

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    logic [31:0] ipv4 [5] = '{32'h45000073, 32'h00004000, 32'h40110000,
                              32'hC0A80001, 32'hC0A800C7};

    // Run one job; start is held high during gaps and output stalls to prove
    // it is ignored while busy, including in the completing handshake cycle.
    task automatic run_job(input string name, input logic [3:0] n,
                           input logic [31:0] w [5], input int gap,
                           input int stall, input logic [15:0] exp);
        logic [15:0] held;
        int          waited;
        start = 1'b1;
        len   = n;
        tick;
        start = 1'b0;
        for (int i = 0; i < int'(n); i++) begin
            in_valid = 1'b1;
            in_data  = w[i];
            tick;
            in_valid = 1'b0;
            in_data  = 32'hDEAD_BEEF;
            if (i != int'(n) - 1) begin
                for (int g = 0; g < gap; g++) begin
                    start = 1'b1;
                    len   = 4'd0;
                    tick;
                    start = 1'b0;
                end
            end
        end
        chk({name, "_latency"}, 32'(out_valid), 32'h1);
        waited = 0;
        while (!out_valid && waited < 20) begin
            tick;
            waited++;
        end
        if (!out_valid) chk({name, "_timeout"}, 32'h0, 32'h1);
        chk({name, "_csum"}, 32'(out_csum), 32'(exp));
        held = out_csum;
        for (int s = 0; s < stall; s++) begin
            start = 1'b1;
            len   = 4'd1;
            tick;
            chk({name, "_stable"}, 32'(out_csum), 32'(held));
        end
        out_ready = 1'b1;
        start     = 1'b1;
        len       = 4'd1;
        tick;
        out_ready = 1'b0;
        start     = 1'b0;
        chk({name, "_gap_idle"}, 32'(busy), 32'h0);
        tick;
    endtask

    logic [31:0] w1 [5];

    initial begin
        rst_n     = 1'b0;
        start     = 1'b0;
        len       = 4'd0;
        in_valid  = 1'b0;
        in_data   = '0;
        out_ready = 1'b0;
        tick;
        tick;
        chk("rst_busy",      32'(busy),      32'h0);
        chk("rst_in_ready",  32'(in_ready),  32'h0);
        chk("rst_out_valid", 32'(out_valid), 32'h0);
        chk("rst_out_csum",  32'(out_csum),  32'h0);
        rst_n = 1'b1;
        tick;

        run_job("ipv4", 4'd5, ipv4, 0, 0, 16'hB861);

        w1 = '{32'hFFFF0001, 32'h0, 32'h0, 32'h0, 32'h0};
        run_job("wrap1", 4'd1, w1, 0, 0, 16'hFFFE);
        w1[0] = 32'hFFFFFFFF;
        run_job("wrap2", 4'd1, w1, 0, 1, 16'h0000);

        // Empty job: straight to the result, never ready for data.
        start = 1'b1;
        len   = 4'd0;
        tick;
        start = 1'b0;
        chk("empty_in_ready",  32'(in_ready),  32'h0);
        chk("empty_out_valid", 32'(out_valid), 32'h1);
        chk("empty_csum",      32'(out_csum),  32'hFFFF);
        out_ready = 1'b1;
        tick;
        out_ready = 1'b0;
        tick;

        run_job("hs", 4'd5, ipv4, 2, 3, 16'hB861);

        // Reset mid-job after two words.
        start = 1'b1;
        len   = 4'd5;
        tick;
        start = 1'b0;
        for (int i = 0; i < 2; i++) begin
            in_valid = 1'b1;
            in_data  = ipv4[i];
            tick;
        end
        in_valid = 1'b0;
        rst_n    = 1'b0;
        tick;
        rst_n = 1'b1;
        chk("midrst_busy",      32'(busy),      32'h0);
        chk("midrst_in_ready",  32'(in_ready),  32'h0);
        chk("midrst_out_valid", 32'(out_valid), 32'h0);
        chk("midrst_out_csum",  32'(out_csum),  32'h0);
        tick;
        run_job("after_rst", 4'd5, ipv4, 1, 0, 16'hB861);

        // Full-length block of 15 words.
        start = 1'b1;
        len   = 4'd15;
        tick;
        start = 1'b0;
        for (int i = 0; i < 15; i++) begin
            in_valid = 1'b1;
            in_data  = 32'hFFFF_FFFF - 32'(i);
            tick;
        end
        in_valid = 1'b0;
        chk("long_out_valid", 32'(out_valid), 32'h1);
        out_ready = 1'b1;
        tick;
        out_ready = 1'b0;
        tick;
        tick;

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
